// File: rtl/vdcm_pkg.sv
// Shared codec definitions: codec word width, substream count and word type.
package vdcm_pkg;

   localparam int CODEC_W = 128;
   localparam int NUM_SSM = 4;

   typedef logic [CODEC_W-1:0] codec_word_t;

endpackage

// File: rtl/ssm_slot_ofs.sv
// Substream slot offsets: for each asserted write enable, the number of
// lower-index substreams also asserted (its slot relative to the write
// pointer), plus the total number of asserted enables.
module ssm_slot_ofs
   import vdcm_pkg::*;
(
   input  logic [NUM_SSM-1:0]      ssm_wr_en,
   output logic [NUM_SSM-1:0][1:0] slot_ofs,
   output logic [2:0]              total
);

   logic [2:0] acc;

   // Running prefix popcount in ascending substream order.
   always_comb begin
      acc      = 3'd0;
      slot_ofs = '0;
      for (int k = 0; k < NUM_SSM; k++) begin
         slot_ofs[k] = acc[1:0];
         acc         = acc + {2'b00, ssm_wr_en[k]};
      end
      total = acc;
   end

endmodule

// File: rtl/ssm_mux.sv
// Encoder-side substream multiplexer: a circular FIFO that accepts up to one
// word from each of the four substream encoders per cycle and emits one word
// per cycle, ordered by cycle first and substream index second.
//
// Handshakes:
//   upstream   - ssm_rdy depends only on registered state; every asserted
//                ssm_wr_en bit in a cycle with ssm_rdy=1 is written; any
//                asserted bit while ssm_rdy=0 drops the whole cycle's words
//                and sets the sticky ovf_err.
//   downstream - a word transfers on a rising edge with mux_vld & mux_rdy;
//                while mux_vld=1 & mux_rdy=0, mux_vld/mux_data hold steady.
module ssm_mux
   import vdcm_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic                       clk,
   input  logic                       rstn,
   input  logic                       flush,
   input  logic [NUM_SSM-1:0]         ssm_wr_en,
   input  codec_word_t                ssm_data0,
   input  codec_word_t                ssm_data1,
   input  codec_word_t                ssm_data2,
   input  codec_word_t                ssm_data3,
   output logic                       ssm_rdy,
   output logic                       mux_vld,
   output codec_word_t                mux_data,
   input  logic                       mux_rdy,
   output logic [$clog2(DEPTH):0]     fifo_level,
   output logic                       ovf_err
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   codec_word_t                mem [DEPTH];
   codec_word_t                din [NUM_SSM];
   logic [AW-1:0]              wr_ptr;
   logic [AW-1:0]              rd_ptr;
   logic [CW-1:0]              cnt;
   logic [NUM_SSM-1:0][1:0]    slot_ofs;
   logic [2:0]                 total;
   logic [2:0]                 n_acc;
   logic                       pop;
   logic                       push_rej;

   assign din[0] = ssm_data0;
   assign din[1] = ssm_data1;
   assign din[2] = ssm_data2;
   assign din[3] = ssm_data3;

   ssm_slot_ofs u_slot_ofs (
      .ssm_wr_en (ssm_wr_en),
      .slot_ofs  (slot_ofs),
      .total     (total)
   );

   // Room for a full four-word push; derived from the count register only.
   assign ssm_rdy    = (cnt <= CW'(DEPTH - NUM_SSM));
   assign mux_vld    = (cnt != '0);
   assign mux_data   = mem[rd_ptr];
   assign fifo_level = cnt;

   assign pop      = mux_vld & mux_rdy;
   assign n_acc    = ssm_rdy ? total : 3'd0;
   assign push_rej = (|ssm_wr_en) & ~ssm_rdy;

   // Storage writes: each accepted word lands at wr_ptr plus its slot offset,
   // wrapping naturally through the pointer width. Contents are not reset.
   always_ff @(posedge clk) begin
      if (ssm_rdy && !flush) begin
         for (int k = 0; k < NUM_SSM; k++) begin
            if (ssm_wr_en[k]) begin
               mem[wr_ptr + AW'(slot_ofs[k])] <= din[k];
            end
         end
      end
   end

   // Pointer, occupancy and sticky overflow flag; flush overrides push/pop
   // but leaves the overflow flag alone.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         cnt     <= '0;
         ovf_err <= 1'b0;
      end else begin
         if (push_rej) begin
            ovf_err <= 1'b1;
         end
         if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
         end else begin
            wr_ptr <= wr_ptr + AW'(n_acc);
            if (pop) begin
               rd_ptr <= rd_ptr + AW'(1);
            end
            cnt <= cnt + CW'(n_acc) - CW'(pop);
         end
      end
   end

endmodule

// File: tb/tb_ssm_mux.sv
// Testbench for ssm_mux: directed scenarios followed by random traffic, all
// checked against a queue-based model of the ordered word stream.
module tb_ssm_mux;

   import vdcm_pkg::*;

   localparam int DEPTH = 16;

   logic              clk;
   logic              rstn;
   logic              flush;
   logic [3:0]        ssm_wr_en;
   logic [127:0]      din [4];
   logic              ssm_rdy;
   logic              mux_vld;
   logic [127:0]      mux_data;
   logic              mux_rdy;
   logic [4:0]        fifo_level;
   logic              ovf_err;

   int                compared   = 0;
   int                mismatched = 0;
   string             phase      = "reset";

   logic [127:0]      exp_q [$];
   logic              ovf_m = 1'b0;

   ssm_mux #(.DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rstn       (rstn),
      .flush      (flush),
      .ssm_wr_en  (ssm_wr_en),
      .ssm_data0  (din[0]),
      .ssm_data1  (din[1]),
      .ssm_data2  (din[2]),
      .ssm_data3  (din[3]),
      .ssm_rdy    (ssm_rdy),
      .mux_vld    (mux_vld),
      .mux_data   (mux_data),
      .mux_rdy    (mux_rdy),
      .fifo_level (fifo_level),
      .ovf_err    (ovf_err)
   );

   // Clock and reset.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s/%s: observed %0h expected %0h", phase, tag, obs, exp);
      end
   endtask

   // Outputs compared against the model of the current contents.
   task automatic check_outputs();
      check("level", 128'(fifo_level), 128'(exp_q.size()));
      check("vld",   128'(mux_vld),    128'(exp_q.size() != 0));
      check("rdy",   128'(ssm_rdy),    128'((DEPTH - exp_q.size()) >= 4));
      check("ovf",   128'(ovf_err),    128'(ovf_m));
      if (exp_q.size() != 0) check("data", mux_data, exp_q[0]);
   endtask

   // Model: an ordered list of words; pushes append in substream order.
   task automatic model_edge();
      bit rdy_m = ((DEPTH - exp_q.size()) >= 4);
      bit pop_m = (exp_q.size() != 0) && mux_rdy;
      if (ssm_wr_en != 4'd0 && !rdy_m) ovf_m = 1'b1;
      if (flush) begin
         exp_q.delete();
      end else begin
         if (pop_m) void'(exp_q.pop_front());
         if (rdy_m) begin
            for (int k = 0; k < 4; k++)
               if (ssm_wr_en[k]) exp_q.push_back(din[k]);
         end
      end
   endtask

   task automatic step();
      check_outputs();
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic drive(input logic [3:0] en, input logic rdy, input logic fl,
                        input logic [127:0] base);
      ssm_wr_en = en;
      mux_rdy   = rdy;
      flush     = fl;
      for (int k = 0; k < 4; k++) din[k] = base + 128'(k);
      step();
   endtask

   task automatic idle(input int n, input logic rdy);
      for (int i = 0; i < n; i++) drive(4'd0, rdy, 1'b0, 128'd0);
   endtask

   initial begin
      rstn      = 1'b0;
      flush     = 1'b0;
      ssm_wr_en = 4'd0;
      mux_rdy   = 1'b0;
      for (int k = 0; k < 4; k++) din[k] = '0;
      repeat (2) @(negedge clk);
      check("rst_vld",   128'(mux_vld),    128'(0));
      check("rst_rdy",   128'(ssm_rdy),    128'(1));
      check("rst_level", 128'(fifo_level), 128'(0));
      check("rst_ovf",   128'(ovf_err),    128'(0));
      rstn = 1'b1;
      @(negedge clk);

      // Single-substream fill.
      phase = "single";
      drive(4'b0001, 1'b1, 1'b0, 128'h01);
      check("vld_after_first", 128'(mux_vld), 128'(1));
      check("first_word", mux_data, 128'h01);
      drive(4'b0001, 1'b1, 1'b0, 128'h02);
      drive(4'b0001, 1'b1, 1'b0, 128'h03);
      idle(3, 1'b1);
      check("level_end", 128'(fifo_level), 128'(0));

      // All-four burst with a stalled reader.
      phase = "burst";
      drive(4'b1111, 1'b0, 1'b0, 128'hA0);
      drive(4'b1111, 1'b0, 1'b0, 128'hB0);
      check("level8", 128'(fifo_level), 128'(8));
      idle(3, 1'b0);
      check("head_stable", mux_data, 128'hA0);
      idle(9, 1'b1);

      // Sparse masks.
      phase = "sparse";
      drive(4'b1010, 1'b0, 1'b0, 128'h10);
      drive(4'b0101, 1'b0, 1'b0, 128'h20);
      check("level4", 128'(fifo_level), 128'(4));
      check("head_ssm1", mux_data, 128'h11);
      idle(5, 1'b1);

      // Wrap-around with simultaneous push and pop.
      phase = "wrap";
      drive(4'b0000, 1'b0, 1'b1, 128'd0);
      drive(4'b1111, 1'b1, 1'b0, 128'h100);
      drive(4'b1111, 1'b1, 1'b0, 128'h200);
      drive(4'b1111, 1'b1, 1'b0, 128'h300);
      idle(11, 1'b1);
      drive(4'b0011, 1'b0, 1'b0, 128'h400);
      check("pre_level", 128'(fifo_level), 128'(2));
      drive(4'b1111, 1'b1, 1'b0, 128'h500);
      check("rise3", 128'(fifo_level), 128'(5));
      idle(6, 1'b1);

      // Backpressure and overflow.
      phase = "ovf";
      drive(4'b1111, 1'b0, 1'b0, 128'h600);
      drive(4'b1111, 1'b0, 1'b0, 128'h700);
      drive(4'b1111, 1'b0, 1'b0, 128'h800);
      drive(4'b0001, 1'b0, 1'b0, 128'h900);
      check("rdy_low_13", 128'(ssm_rdy), 128'(0));
      drive(4'b0011, 1'b0, 1'b0, 128'hA00);
      check("level_held", 128'(fifo_level), 128'(13));
      check("ovf_set", 128'(ovf_err), 128'(1));
      drive(4'b0000, 1'b1, 1'b0, 128'd0);
      check("rdy_back_12", 128'(ssm_rdy), 128'(1));
      drive(4'b0000, 1'b0, 1'b1, 128'd0);
      check("ovf_after_flush", 128'(ovf_err), 128'(1));

      // Flush with a concurrent push, then asynchronous reset.
      phase = "flush";
      drive(4'b1111, 1'b0, 1'b0, 128'hB00);
      drive(4'b0011, 1'b0, 1'b0, 128'hC00);
      check("level6", 128'(fifo_level), 128'(6));
      drive(4'b1111, 1'b1, 1'b1, 128'hD00);
      check("flush_level", 128'(fifo_level), 128'(0));
      check("flush_vld",   128'(mux_vld),    128'(0));
      drive(4'b1111, 1'b1, 1'b0, 128'hE00);
      drive(4'b1111, 1'b1, 1'b0, 128'hF00);
      phase = "async_rst";
      #2 rstn = 1'b0;
      #1;
      check("vld",   128'(mux_vld),    128'(0));
      check("rdy",   128'(ssm_rdy),    128'(1));
      check("level", 128'(fifo_level), 128'(0));
      check("ovf",   128'(ovf_err),    128'(0));
      exp_q.delete();
      ovf_m     = 1'b0;
      ssm_wr_en = 4'd0;
      @(negedge clk);
      rstn = 1'b1;
      idle(1, 1'b1);

      // Random traffic.
      phase = "random";
      for (int i = 0; i < 400; i++) begin
         ssm_wr_en = 4'($urandom_range(0, 15));
         mux_rdy   = (i % 100 < 50) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
         flush     = ($urandom_range(0, 39) == 0);
         for (int k = 0; k < 4; k++) din[k] = {$urandom, $urandom, $urandom, $urandom};
         step();
      end
      idle(DEPTH + 2, 1'b1);
      check("drained", 128'(fifo_level), 128'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/ssm_mux.md
# ssm_mux

Encoder-side substream multiplexer. Collects 128-bit mux words from the four substream encoders (ssm0..ssm3) and serializes them into one ordered codec word stream. Ordering matches what the decoder-side substream parsers expect when they pull words from a flat memory:
- earlier cycles first;
- within one cycle, lower substream index first.

The block is a circular FIFO with multi-word write and single-word read, placed between the substream encoders and the bitstream output/memory writer.

## Interface
- `DEPTH`, 16 — FIFO entries; power of two, ≥ 8.
- `clk`  in  1  — clock.
- `rstn`  in  1  — reset. Asynchronous, active-low.
- `flush`  in  1  — synchronous clear of the FIFO contents; `ovf_err` is kept.
- `ssm_wr_en`  in  4  — bit k: substream k pushes one word this cycle.
- `ssm_data0..ssm_data3`  in  128 each  — word pushed by substream 0..3.
- `ssm_rdy`  out  1  — at least 4 free entries; pushes are accepted.
- `mux_vld`  out  1  — `mux_data` holds a valid word.
- `mux_data`  out  128  — head-of-FIFO word.
- `mux_rdy`  in  1  — downstream accepts the word.
- `fifo_level`  out  $clog2(DEPTH)+1  — occupied entries.
- `ovf_err`  out  1  — sticky: a push was attempted while `ssm_rdy` was 0.

## Operation
- **State:** `mem[DEPTH]` of 128 bits; `wr_ptr` and `rd_ptr`, each $clog2(DEPTH) bits and wrapping modulo DEPTH; `cnt` of `fifo_level` width.
- **Push.** When `ssm_rdy=1`, let n = popcount(`ssm_wr_en`), 0..4. The asserted substreams are written in ascending index order:
  - the i-th asserted substream (i = 0..n-1) writes to `mem[(wr_ptr+i) mod DEPTH]`;
  - `wr_ptr` advances by n.
  - Example: `ssm_wr_en`=4'b1010 writes `ssm_data1` to `wr_ptr` and `ssm_data3` to `wr_ptr+1`.
- **Pop.** When `mux_vld & mux_rdy`, `rd_ptr` advances by 1.
- **Count update:** `cnt_next = cnt + n_accepted − pop`. Push and pop in the same cycle are legal, including when the FIFO is full or empty.
- **Rejected push.** If `ssm_wr_en`≠0 while `ssm_rdy`=0:
  - all words of that cycle are dropped, never a partial write;
  - pointers are unchanged except by a pop;
  - `ovf_err` is set to 1 and held until reset.
- **Flush.** `flush=1` sets `wr_ptr`, `rd_ptr` and `cnt` to 0 at the next edge. It has priority over a push or pop in the same cycle. `ovf_err` is not cleared by flush.
- **Combinational outputs:**
  - `ssm_rdy = (DEPTH − cnt) ≥ 4`, from registered state only;
  - `mux_vld = (cnt ≠ 0)`;
  - `mux_data = mem[rd_ptr]`. When `mux_vld`=0, `mux_data` is don't-care.
- **Wrap-around.** A multi-word push that crosses the `mem[DEPTH-1]`→`mem[0]` boundary splits correctly.

## Timing
- **Reset values:** `mux_vld`=0, `ssm_rdy`=1, `fifo_level`=0, `ovf_err`=0, pointers 0. `mux_data` is don't-care. Memory contents are not reset.
- **Latency:** a word pushed at edge t appears on `mux_data`/`mux_vld` after edge t when the FIFO was empty. There is no same-cycle bypass.
- **Throughput:** up to 4 words in and 1 word out per cycle. `ssm_rdy` deasserts once `cnt` > DEPTH−4 and reasserts the cycle after `cnt` falls to DEPTH−4 or below.
- **Downstream handshake:** `mux_data` and `mux_vld` stay stable while `mux_vld=1 & mux_rdy=0`; pushes never change the head word.
- **Reset mid-operation:** `rstn` low drops all contents immediately (asynchronous). Outputs go to their reset values while `rstn`=0.

## Structure
- **Shared package `vdcm_pkg`:**
  - `CODEC_W`=128 and `NUM_SSM`=4;
  - `codec_word_t`, a typedef for a 128-bit word.
- **Sub-module `ssm_slot_ofs`:** combinational. It takes `ssm_wr_en[3:0]` and produces the per-substream slot offset (prefix popcount, 2 bits each) and the total n (3 bits). It is reused by the decoder-side word fetch.
- **`ssm_mux` owns:** the pointers, count, memory array and error flag.

## Test plan
1. **Single-substream fill:**
   - Stimulus: after reset, `ssm_wr_en`=4'b0001 for 3 cycles with data 0x..01, 0x..02, 0x..03, `mux_rdy`=1.
   - Required: `mux_vld` from the cycle after the first push; `mux_data` shows 01, 02, 03 in order; `fifo_level` returns to 0.
2. **All-four burst with stalled reader:**
   - Stimulus: `ssm_wr_en`=4'b1111 with data A0..A3, then B0..B3, with `mux_rdy`=0.
   - Required: `fifo_level`=8. After `mux_rdy`=1, the output order is A0,A1,A2,A3,B0,…,B3.
3. **Sparse mask ordering:**
   - Stimulus: masks 4'b1010 then 4'b0101.
   - Required: output order is ssm1, ssm3, ssm0, ssm2; `fifo_level` peaks at 4.
4. **Backpressure and overflow (DEPTH=16):**
   - Stimulus: fill to 13 entries, then push 4'b0011.
   - Required: `ssm_rdy`=0 at `cnt`=13; the push is dropped; `fifo_level` stays 13; `ovf_err`=1 and remains 1 after a flush.
5. **Wrap plus simultaneous push/pop:**
   - Stimulus: advance the pointers to `wr_ptr`=14, then push 4'b1111 while popping.
   - Required: words land in slots 14,15,0,1; `fifo_level` rises by exactly 3; data order is preserved.
6. **Flush and asynchronous reset:**
   - Stimulus: with 6 entries, assert `flush` together with a push.
   - Required: `fifo_level`=0 and `mux_vld`=0 next cycle.
   - Stimulus: then drop `rstn` mid-burst.
   - Required: all outputs take their reset values immediately.
